// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, default bit timing,
// line levels and a parity helper used by both transmit and receive sides.
package uart_pkg;

    // Transmitter frame phases.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // 9600 baud from a 10 MHz clock.
    localparam int CLKS_PER_BIT_DEF = 1042;

    localparam int DATA_BITS = 8;

    // Line levels shared with the receiver.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // Parity over a data byte; odd sense inverts the even result.
    function automatic logic parity_bit(
        input logic [7:0] data,
        input logic       odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Ports: clk, rst (sync, active-high), clr (hold at zero), tick (last cycle of bit).
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    localparam logic [W-1:0] ONE  = W'(1);

    generate
        if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
            $error("uart_baud_cnt: CLKS_PER_BIT must be in 2..65535");
        end
    endgenerate

    logic [W-1:0] cnt;

    // Wrapping on tick keeps every bit exactly CLKS_PER_BIT cycles long,
    // so consecutive bits never accumulate drift.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1-2 stops.
// Ports: clk, rst (sync, active-high), TxByte/TxStart (request), RsTx (line),
//        TxBusy (frame in flight), TxDone (one-cycle pulse at frame end).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] TxByte,
    input  logic       TxStart,
    output logic       RsTx,
    output logic       TxBusy,
    output logic       TxDone
);

    generate
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       PAR_ON    = (PARITY_EN != 0);
    localparam logic       PAR_ODD   = (PARITY_ODD != 0);

    tx_state_t  state;
    tx_state_t  state_n;
    logic [7:0] shift_q;
    logic [7:0] shift_n;
    logic [2:0] bit_q;
    logic [2:0] bit_n;
    logic       par_q;
    logic       par_n;
    logic       tx_q;
    logic       tx_n;
    logic       busy_q;
    logic       busy_n;
    logic       done_q;
    logic       done_n;
    logic       tick;

    // Counter idles at zero so the start bit gets a full period from acceptance.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk (clk),
        .rst (rst),
        .clr (state == IDLE),
        .tick(tick)
    );

    // Next-state logic also computes the next line level, so RsTx is a flop
    // output with no combinational path from the inputs.
    always_comb begin
        state_n = state;
        shift_n = shift_q;
        bit_n   = bit_q;
        par_n   = par_q;
        tx_n    = tx_q;
        busy_n  = busy_q;
        done_n  = 1'b0;

        unique case (state)
            IDLE: begin
                tx_n   = LINE_IDLE;
                busy_n = 1'b0;
                if (TxStart) begin
                    state_n = START;
                    shift_n = TxByte;
                    // Parity is taken from the byte as latched, before shifting.
                    par_n   = parity_bit(TxByte, PAR_ODD);
                    bit_n   = '0;
                    tx_n    = LINE_START;
                    busy_n  = 1'b1;
                end
            end

            START: begin
                if (tick) begin
                    state_n = DATA;
                    tx_n    = shift_q[0];
                end
            end

            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_DATA) begin
                        bit_n = '0;
                        if (PAR_ON) begin
                            state_n = PARITY;
                            tx_n    = par_q;
                        end else begin
                            state_n = STOP;
                            tx_n    = LINE_IDLE;
                        end
                    end else begin
                        shift_n = {1'b0, shift_q[7:1]};
                        bit_n   = bit_q + 3'd1;
                        tx_n    = shift_q[1];
                    end
                end
            end

            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    bit_n   = '0;
                    tx_n    = LINE_IDLE;
                end
            end

            STOP: begin
                tx_n = LINE_IDLE;
                if (tick) begin
                    // bit_q counts stop bits here.
                    if (bit_q == LAST_STOP) begin
                        state_n = IDLE;
                        bit_n   = '0;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        bit_n = bit_q + 3'd1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = LINE_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= LINE_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            shift_q <= shift_n;
            bit_q   <= bit_n;
            par_q   <= par_n;
            tx_q    <= tx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    assign RsTx   = tx_q;
    assign TxBusy = busy_q;
    assign TxDone = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, reset abort, busy/back-to-back,
// parity and stop variants, and a 9600-baud loopback through a receive model.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] start;
    logic [3:0] rs_tx;
    logic [3:0] busy;
    logic [3:0] done;
    logic [7:0] tx_byte [4];

    int n_cmp = 0;
    int n_bad = 0;

    logic smp [0:16383];
    int   done_at;
    int   done_cnt;

    always #50 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(16)) u0 (
        .clk(clk), .rst(rst), .TxByte(tx_byte[0]), .TxStart(start[0]),
        .RsTx(rs_tx[0]), .TxBusy(busy[0]), .TxDone(done[0])
    );

    uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0),
              .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .TxByte(tx_byte[1]), .TxStart(start[1]),
        .RsTx(rs_tx[1]), .TxBusy(busy[1]), .TxDone(done[1])
    );

    uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(1),
              .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .TxByte(tx_byte[2]), .TxStart(start[2]),
        .RsTx(rs_tx[2]), .TxBusy(busy[2]), .TxDone(done[2])
    );

    uart_tx #(.CLKS_PER_BIT(1042)) u3 (
        .clk(clk), .rst(rst), .TxByte(tx_byte[3]), .TxStart(start[3]),
        .RsTx(rs_tx[3]), .TxBusy(busy[3]), .TxDone(done[3])
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Request one frame; line must fall and busy rise one edge later.
    task automatic kick(input int i, input logic [7:0] b);
        @(negedge clk);
        tx_byte[i] = b;
        start[i]   = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        chk("lat_tx", 32'(rs_tx[i]), 32'd0);
        chk("lat_busy", 32'(busy[i]), 32'd1);
    endtask

    // Record the line one sample per negedge; index 0 is the first low sample.
    task automatic capture(input int i, input int len);
        bit seen;
        seen     = 1'b0;
        done_at  = -1;
        done_cnt = 0;
        for (int k = 0; k < 4000 && !seen; k++) begin
            @(negedge clk);
            if (rs_tx[i] == 1'b0) seen = 1'b1;
        end
        chk("fall_seen", 32'(seen), 32'd1);
        if (seen) begin
            for (int k = 0; k < len; k++) begin
                if (k > 0) @(negedge clk);
                smp[k] = rs_tx[i];
                if (done[i]) begin
                    done_cnt++;
                    if (done_at < 0) done_at = k;
                end
            end
        end
    endtask

    // Receive model: data bits sampled at bit centres.
    function automatic logic [7:0] dec(input int base, input int c);
        logic [7:0] d;
        for (int b = 0; b < 8; b++) d[b] = smp[base + (b + 1) * c + c / 2];
        return d;
    endfunction

    function automatic int cnt_lvl(input int from, input int n, input logic v);
        int m;
        m = 0;
        for (int k = from; k < from + n; k++) if (smp[k] == v) m++;
        return m;
    endfunction

    initial begin
        logic [9:0] lv1;
        logic [7:0] lb [4];
        int         lows;
        int         dn;

        lv1 = 10'b1001111110;
        lb  = '{8'h3F, 8'h00, 8'hFF, 8'h81};

        rst   = 1'b1;
        start = '0;
        for (int i = 0; i < 4; i++) tx_byte[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(rs_tx), 32'hF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic frame 0x3F at 16 clocks per bit.
        kick(0, 8'h3F);
        capture(0, 168);
        for (int b = 0; b < 10; b++)
            chk($sformatf("hold%0d", b), 32'(cnt_lvl(b * 16, 16, lv1[b])), 32'd16);
        chk("basic_byte", 32'(dec(0, 16)), 32'h3F);
        chk("basic_done_at", 32'(done_at), 32'd160);
        chk("basic_done_cnt", 32'(done_cnt), 32'd1);
        chk("basic_idle_busy", 32'(busy[0]), 32'd0);

        // Reset in the middle of data bit 3.
        kick(0, 8'h00);
        repeat (70) @(negedge clk);
        chk("rst_mid_pre", 32'(rs_tx[0]), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_tx", 32'(rs_tx[0]), 32'd1);
        chk("rst_mid_busy", 32'(busy[0]), 32'd0);
        chk("rst_mid_done", 32'(done[0]), 32'd0);
        rst = 1'b0;
        dn  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done[0]) dn++;
        end
        chk("rst_mid_nodone", 32'(dn), 32'd0);
        kick(0, 8'hA5);
        capture(0, 168);
        chk("rst_after_byte", 32'(dec(0, 16)), 32'hA5);
        chk("rst_after_done", 32'(done_at), 32'd160);

        // Busy rejection and back-to-back start in the TxDone cycle.
        kick(0, 8'h55);
        fork
            capture(0, 329);
            begin
                bit seen;
                repeat (60) @(negedge clk);
                tx_byte[0] = 8'hFF;
                start[0]   = 1'b1;
                @(negedge clk);
                start[0] = 1'b0;
                seen     = 1'b0;
                for (int k = 0; k < 400 && !seen; k++) begin
                    @(negedge clk);
                    if (done[0]) seen = 1'b1;
                end
                chk("b2b_done_seen", 32'(seen), 32'd1);
                tx_byte[0] = 8'h0F;
                start[0]   = 1'b1;
                @(posedge clk);
                #1;
                start[0]   = 1'b0;
                tx_byte[0] = 8'hFF;
                chk("b2b_busy", 32'(busy[0]), 32'd1);
            end
        join
        chk("b2b_byte0", 32'(dec(0, 16)), 32'h55);
        chk("b2b_gap_hi", 32'(smp[160]), 32'd1);
        chk("b2b_gap_lo", 32'(smp[161]), 32'd0);
        chk("b2b_byte1", 32'(dec(161, 16)), 32'h0F);
        chk("b2b_stop1", 32'(smp[161 + 9 * 16 + 8]), 32'd1);
        chk("b2b_done_cnt", 32'(done_cnt), 32'd2);
        lows = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (rs_tx[0] == 1'b0) lows++;
        end
        chk("b2b_quiet", 32'(lows), 32'd0);

        // Even parity, two stop bits.
        kick(1, 8'h07);
        capture(1, 200);
        chk("par_e_byte", 32'(dec(0, 16)), 32'h07);
        chk("par_e_bit", 32'(cnt_lvl(144, 16, 1'b1)), 32'd16);
        chk("par_e_stop", 32'(cnt_lvl(160, 32, 1'b1)), 32'd32);
        chk("par_e_len", 32'(done_at), 32'd192);

        // Odd parity, two stop bits.
        kick(2, 8'h07);
        capture(2, 200);
        chk("par_o_byte", 32'(dec(0, 16)), 32'h07);
        chk("par_o_bit", 32'(cnt_lvl(144, 16, 1'b0)), 32'd16);
        chk("par_o_stop", 32'(cnt_lvl(160, 32, 1'b1)), 32'd32);
        chk("par_o_len", 32'(done_at), 32'd192);

        // 9600 baud loopback into the receive model.
        for (int n = 0; n < 4; n++) begin
            kick(3, lb[n]);
            capture(3, 10 * 1042 + 4);
            chk("loop_byte", 32'(dec(0, 1042)), 32'(lb[n]));
            chk("loop_stop", 32'(smp[9 * 1042 + 521]), 32'd1);
            chk("loop_done", 32'(done_at), 32'd10420);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
